rv_test_monitor: RTL and testbench

RV_TEST_MONITOR -- requirements
Module: rv_test_monitor

---
 rtl/rv_test_pkg.sv | 20 ++
 rtl/rv_monitor_slot.sv | 40 ++++
 rtl/rv_test_monitor.sv | 172 +++++++++++++++++
 tb/tb_rv_test_monitor.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_test_pkg.sv
// Shared types and constants for the RISC-V test-completion monitor.
package rv_test_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CHECK = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    localparam logic [31:0] EBREAK_32   = 32'h0010_0073;
    localparam logic [15:0] C_EBREAK_16 = 16'h9002;

    // True for a retired ebreak or c.ebreak; the upper half is ignored for the compressed form.
    function automatic logic is_ebreak(input logic valid, input logic [31:0] instr);
        return valid && ((instr == EBREAK_32) || (instr[15:0] == C_EBREAK_16));
    endfunction

endpackage

// File: rtl/rv_monitor_slot.sv
// One expected-register check slot: shadows the last write to its register and compares it.
module rv_monitor_slot #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            capture_en,
    input  logic            wb_valid,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    input  logic [4:0]      exp_rd,
    input  logic [XLEN-1:0] exp_val,
    output logic            mismatch_c
);

    logic [XLEN-1:0] shadow_q;
    logic [XLEN-1:0] shadow_d;
    logic            capture_c;

    // x0 is never written, so a slot watching x0 keeps comparing against zero.
    assign capture_c = capture_en && wb_valid && (wb_rd == exp_rd) && (wb_rd != 5'd0);

    always_comb begin
        shadow_d = shadow_q;
        if (capture_c) begin
            shadow_d = wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
        end else begin
            shadow_q <= shadow_d;
        end
    end

    assign mismatch_c = (shadow_q != exp_val);

endmodule

// File: rtl/rv_test_monitor.sv
// Test-completion monitor: runs until ebreak or timeout, drains, then checks register slots.
// Optional RV_TEST_MONITOR_TRACE_EN adds simulation trace of captures and the final result.
module rv_test_monitor
    import rv_test_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned NUM_CHECKS     = 4,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       wb_valid,
    input  logic [4:0]                 wb_rd,
    input  logic [XLEN-1:0]            wb_data,
    input  logic                       retire_valid,
    input  logic [31:0]                retire_instr,
    input  logic [NUM_CHECKS*5-1:0]    exp_rd,
    input  logic [NUM_CHECKS*XLEN-1:0] exp_val,
    output logic                       done,
    output logic                       pass,
    output logic                       fail,
    output logic                       timeout,
    output logic [NUM_CHECKS-1:0]      fail_mask,
    output logic [31:0]                cycle_count
);

    localparam int unsigned DCW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    state_e                state_q, state_d;
    logic [DCW-1:0]        drain_cnt_q, drain_cnt_d;
    logic [31:0]           cycle_count_q, cycle_count_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic                  fail_q, fail_d;
    logic                  timeout_q, timeout_d;
    logic [NUM_CHECKS-1:0] fail_mask_q, fail_mask_d;

    logic                  active_c;
    logic                  ebreak_c;
    logic                  timeout_hit_c;
    logic [NUM_CHECKS-1:0] mismatch_c;

    assign active_c      = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign ebreak_c      = is_ebreak(retire_valid, retire_instr);
    assign timeout_hit_c = active_c && (cycle_count_q == 32'(TIMEOUT_CYCLES - 1));

    for (genvar i = 0; i < NUM_CHECKS; i++) begin : g_slot
        rv_monitor_slot #(
            .XLEN(XLEN)
        ) u_slot (
            .clk        (clk),
            .reset      (reset),
            .capture_en (active_c),
            .wb_valid   (wb_valid),
            .wb_rd      (wb_rd),
            .wb_data    (wb_data),
            .exp_rd     (exp_rd[5*i +: 5]),
            .exp_val    (exp_val[XLEN*i +: XLEN]),
            .mismatch_c (mismatch_c[i])
        );
    end

    // Next-state and registered-output logic; timeout takes priority over ebreak and drain end.
    always_comb begin
        state_d       = state_q;
        drain_cnt_d   = drain_cnt_q;
        cycle_count_d = cycle_count_q;
        done_d        = done_q;
        pass_d        = pass_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        fail_mask_d   = fail_mask_q;

        if (active_c) begin
            cycle_count_d = cycle_count_q + 32'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (timeout_hit_c) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (ebreak_c) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (timeout_hit_c) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    fail_d    = 1'b1;
                    timeout_d = 1'b1;
                end else if (drain_cnt_q == DCW'(SETTLE_CYCLES - 1)) begin
                    state_d = ST_CHECK;
                end else begin
                    drain_cnt_d = drain_cnt_q + DCW'(1);
                end
            end
            ST_CHECK: begin
                state_d     = ST_DONE;
                fail_mask_d = mismatch_c;
                done_d      = 1'b1;
                pass_d      = ~|mismatch_c;
                fail_d      = |mismatch_c;
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            drain_cnt_q   <= '0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_q        <= 1'b0;
            timeout_q     <= 1'b0;
            fail_mask_q   <= '0;
        end else begin
            state_q       <= state_d;
            drain_cnt_q   <= drain_cnt_d;
            cycle_count_q <= cycle_count_d;
            done_q        <= done_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
            fail_mask_q   <= fail_mask_d;
        end
    end

    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout     = timeout_q;
    assign fail_mask   = fail_mask_q;
    assign cycle_count = cycle_count_q;

`ifdef RV_TEST_MONITOR_TRACE_EN
    always @(posedge clk) begin
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < NUM_CHECKS; i++) begin
            if (exp_rd[5*i +: 5] == wb_rd) hit = 1'b1;
        end
        if (!reset && active_c && wb_valid && (wb_rd != 5'd0) && hit) begin
            $display("rv_test_monitor: cycle=%0d capture x%0d=0x%h", cycle_count_q, wb_rd, wb_data);
        end
        if (!reset && (state_q != ST_DONE) && (state_d == ST_DONE)) begin
            $display("rv_test_monitor: result=%s cycle_count=%0d fail_mask=%b",
                     timeout_d ? "TIMEOUT" : (fail_d ? "FAIL" : "PASS"),
                     cycle_count_d, fail_mask_d);
        end
    end
`endif

endmodule

// File: tb/tb_rv_test_monitor.sv
// Directed bench for rv_test_monitor with a timeline-based reference model checked every cycle.
module tb_rv_test_monitor;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NC   = 4;
    localparam int unsigned S    = 4;
    localparam int unsigned TO   = 100;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             wb_valid;
    logic [4:0]       wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic             retire_valid;
    logic [31:0]      retire_instr;
    logic [NC*5-1:0]  exp_rd;
    logic [NC*XLEN-1:0] exp_val;
    logic             done, pass, fail, timeout;
    logic [NC-1:0]    fail_mask;
    logic [31:0]      cycle_count;

    int n_vec  = 0;
    int n_fail = 0;

    rv_test_monitor #(
        .XLEN(XLEN), .NUM_CHECKS(NC), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .retire_valid(retire_valid), .retire_instr(retire_instr),
        .exp_rd(exp_rd), .exp_val(exp_val),
        .done(done), .pass(pass), .fail(fail), .timeout(timeout),
        .fail_mask(fail_mask), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // ---------------- reference model: run timeline relative to start ----------------
    bit          m_valid = 0;
    bit          m_started;
    int          m_t;
    int          m_eb;
    logic [31:0] m_shadow [NC];
    logic [31:0] m_cc;
    bit          m_done, m_pass, m_fail, m_to;
    logic [NC-1:0] m_mask;

    always @(posedge clk) begin
        if (reset) begin
            m_valid = 1; m_started = 0; m_t = 0; m_eb = -1; m_cc = 0;
            m_done = 0; m_pass = 0; m_fail = 0; m_to = 0; m_mask = '0;
            for (int i = 0; i < NC; i++) m_shadow[i] = '0;
        end else if (!m_started) begin
            if (start) begin m_started = 1; m_t = 0; m_eb = -1; end
        end else if (!m_done) begin
            if (m_eb < 0 || m_t <= m_eb + int'(S)) begin
                if (wb_valid && wb_rd != 5'd0)
                    for (int i = 0; i < NC; i++)
                        if (exp_rd[5*i +: 5] == wb_rd) m_shadow[i] = wb_data;
                if (m_cc == TO - 1) begin
                    m_done = 1; m_to = 1; m_fail = 1;
                end else if (m_eb < 0 && retire_valid &&
                             (retire_instr == 32'h0010_0073 || retire_instr[15:0] == 16'h9002)) begin
                    m_eb = m_t;
                end
                m_cc = m_cc + 1;
            end else begin
                for (int i = 0; i < NC; i++) m_mask[i] = (m_shadow[i] != exp_val[XLEN*i +: XLEN]);
                m_done = 1; m_pass = (m_mask == '0); m_fail = (m_mask != '0);
            end
            m_t++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_done",    32'(done),        32'(m_done));
            chk("model_pass",    32'(pass),        32'(m_pass));
            chk("model_fail",    32'(fail),        32'(m_fail));
            chk("model_timeout", 32'(timeout),     32'(m_to));
            chk("model_mask",    32'(fail_mask),   32'(m_mask));
            chk("model_cycles",  cycle_count,      m_cc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic wv, input logic [4:0] rd, input logic [31:0] d,
                        input logic rv, input logic [31:0] ins);
        wb_valid = wv; wb_rd = rd; wb_data = d; retire_valid = rv; retire_instr = ins;
        @(posedge clk); #1;
        wb_valid = 0; wb_rd = '0; wb_data = '0; retire_valid = 0; retire_instr = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 5'd0, 32'd0, 0, 32'd0);
    endtask

    task automatic wr(input logic [4:0] rd, input logic [31:0] d);
        step(1, rd, d, 0, 32'd0);
    endtask

    task automatic ebrk(input logic [31:0] ins);
        step(0, 5'd0, 32'd0, 1, ins);
    endtask

    task automatic do_reset();
        reset = 1; idle(2); reset = 0;
    endtask

    task automatic go();
        start = 1; idle(1); start = 0;
    endtask

    task automatic set_slots(input logic [4:0] r0, input logic [31:0] v0,
                             input logic [4:0] r1, input logic [31:0] v1,
                             input logic [4:0] r2, input logic [31:0] v2,
                             input logic [4:0] r3, input logic [31:0] v3);
        exp_rd  = {r3, r2, r1, r0};
        exp_val = {v3, v2, v1, v0};
    endtask

    task automatic wait_done(input int max, output int n);
        n = 0;
        while (!done && n < max) begin idle(1); n++; end
        if (!done) begin
            n_vec++; n_fail++;
            $display("FAIL wait_done: done still 0 after %0d cycles", max);
        end
    endtask

    // Run cycles 0..8: x10 written at 2, x11=5 at 4, ebreak-style retire at 8.
    task automatic basic_run(input logic [31:0] x10v, input logic [31:0] eb_ins, output int lat);
        do_reset();
        set_slots(5'd10, 32'd15, 5'd11, 32'd5, 5'd0, 32'd0, 5'd12, 32'd0);
        go();
        idle(2); wr(5'd10, x10v); idle(1); wr(5'd11, 32'd5); idle(3);
        ebrk(eb_ins);
        wait_done(20, lat);
    endtask

    int lat;

    initial begin
        reset = 1; start = 0;
        wb_valid = 0; wb_rd = '0; wb_data = '0; retire_valid = 0; retire_instr = '0;
        set_slots(5'd10, 32'd15, 5'd11, 32'd5, 5'd0, 32'd0, 5'd12, 32'd0);
        do_reset();
        chk("reset_done",   32'(done), 32'd0);
        chk("reset_cycles", cycle_count, 32'd0);
        idle(3);
        chk("idle_no_start_cycles", cycle_count, 32'd0);

        // 32-bit ebreak at run cycle 8: done S+1 edges later, 8+1+S active cycles.
        basic_run(32'd15, 32'h0010_0073, lat);
        chk("a_latency", 32'(lat), 32'(S + 1));
        chk("a_pass",    32'(pass), 32'd1);
        chk("a_mask",    32'(fail_mask), 32'd0);
        chk("a_cycles",  cycle_count, 32'd13);
        // terminal DONE ignores further activity
        start = 1; wr(5'd10, 32'd1); ebrk(32'h0010_0073); start = 0; idle(2);
        chk("a_sticky_pass",   32'(pass), 32'd1);
        chk("a_sticky_cycles", cycle_count, 32'd13);

        // c.ebreak
        basic_run(32'd15, 32'h0000_9002, lat);
        chk("b_latency", 32'(lat), 32'(S + 1));
        chk("b_pass",    32'(pass), 32'd1);
        chk("b_cycles",  cycle_count, 32'd13);

        // x10 mismatch
        basic_run(32'd14, 32'h0010_0073, lat);
        chk("c_latency", 32'(lat), 32'(S + 1));
        chk("c_fail",    32'(fail), 32'd1);
        chk("c_pass",    32'(pass), 32'd0);
        chk("c_mask",    32'(fail_mask), 32'b0001);

        // near-miss encodings do not terminate; run times out
        do_reset();
        go();
        ebrk(32'h0010_0033); ebrk(32'h0000_9003);
        wait_done(150, lat);
        chk("d_latency", 32'(lat + 2), 32'(TO));
        chk("d_timeout", 32'(timeout), 32'd1);
        chk("d_fail",    32'(fail), 32'd1);
        chk("d_pass",    32'(pass), 32'd0);
        chk("d_mask",    32'(fail_mask), 32'd0);
        chk("d_cycles",  cycle_count, 32'd100);

        // late fix-up during DRAIN; x0 write ignored; write in ebreak cycle captured
        do_reset();
        set_slots(5'd10, 32'd15, 5'd11, 32'd5, 5'd0, 32'd0, 5'd12, 32'd0);
        go();
        idle(2); wr(5'd10, 32'd0); wr(5'd0, 32'd7); idle(4);
        step(1, 5'd11, 32'd5, 1, 32'h0010_0073);
        idle(1); wr(5'd10, 32'd15);
        wait_done(20, lat);
        chk("e_latency", 32'(lat), 32'(S - 1));
        chk("e_pass",    32'(pass), 32'd1);
        chk("e_mask",    32'(fail_mask), 32'd0);

        // duplicate rd slots and an x0 slot expecting non-zero
        do_reset();
        set_slots(5'd10, 32'd15, 5'd11, 32'd5, 5'd0, 32'd9, 5'd10, 32'd15);
        go();
        wr(5'd10, 32'd3); wr(5'd11, 32'd5); wr(5'd0, 32'd9); wr(5'd10, 32'd15);
        ebrk(32'h0010_0073);
        wait_done(20, lat);
        chk("f_mask", 32'(fail_mask), 32'b0100);
        chk("f_fail", 32'(fail), 32'd1);

        // timeout beats an ebreak retiring in the final run cycle
        do_reset();
        set_slots(5'd10, 32'd15, 5'd11, 32'd5, 5'd0, 32'd0, 5'd12, 32'd0);
        go();
        idle(TO - 1);
        ebrk(32'h0010_0073);
        chk("g_done",    32'(done), 32'd1);
        chk("g_timeout", 32'(timeout), 32'd1);
        chk("g_cycles",  cycle_count, 32'd100);

        // reset in RUN at cycle 5 clears everything, then a fresh run passes
        do_reset();
        go();
        wr(5'd10, 32'd15); idle(4);
        reset = 1; idle(1); reset = 0;
        chk("h_done",   32'(done), 32'd0);
        chk("h_cycles", cycle_count, 32'd0);
        chk("h_mask",   32'(fail_mask), 32'd0);
        idle(3);
        chk("h_idle_cycles", cycle_count, 32'd0);
        go();
        idle(2); wr(5'd11, 32'd5); idle(1); wr(5'd10, 32'd15); idle(3);
        ebrk(32'h0010_0073);
        wait_done(20, lat);
        chk("h_pass", 32'(pass), 32'd1);

        // reset mid-DRAIN aborts with no residue
        do_reset();
        go();
        wr(5'd10, 32'd15); ebrk(32'h0010_0073); idle(2);
        reset = 1; idle(1); reset = 0;
        idle(8);
        chk("i_done",   32'(done), 32'd0);
        chk("i_cycles", cycle_count, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
